// File: rtl/page_order_sched.sv
// Page-order checker: buffers one update of page numbers, scans every ordered
// pair through a shared rule-lookup port, and reports verdict, middle page and totals.
module page_order_sched #(
  parameter int MAX_PAGES = 32,
  parameter int SUM_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       page_in,
  input  logic             page_valid,
  input  logic             page_last,
  output logic             page_ready,
  output logic             lk_req,
  output logic [6:0]       lk_x,
  output logic [6:0]       lk_y,
  input  logic             lk_gnt,
  input  logic             lk_hit,
  output logic             res_valid,
  output logic             res_ok,
  output logic [6:0]       res_mid,
  output logic             res_err,
  output logic [SUM_W-1:0] sum_out,
  output logic [15:0]      ok_count
);

  localparam int IW = $clog2(MAX_PAGES);
  localparam int CW = IW + 1;
  localparam logic [CW-1:0] FULLN = CW'(MAX_PAGES);
  localparam logic [CW-1:0] LASTN = CW'(MAX_PAGES - 1);

  typedef enum logic [1:0] {
    COLLECT,
    CHECK,
    WAIT_HIT,
    REPORT
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_n;
  logic [CW-1:0]    r_i;
  logic [CW-1:0]    r_j;
  logic             r_err;
  logic             r_ok;
  logic [SUM_W-1:0] r_sum;
  logic [15:0]      r_cnt;
  logic [6:0]       r_pg [MAX_PAGES];

  logic             w_acc;
  logic             w_full;
  logic             w_row_end;
  logic             w_last_pair;
  logic [IW-1:0]    w_mid_sel;
  logic [6:0]       w_mid;
  logic             w_pend;

  assign w_acc       = page_valid && page_ready;
  assign w_full      = (r_n == LASTN);
  assign w_row_end   = (r_j == r_n - 1'b1);
  assign w_last_pair = w_row_end && (r_i == r_n - CW'(2));
  assign w_mid_sel   = IW'((r_n - 1'b1) >> 1);
  assign w_mid       = r_pg[w_mid_sel];
  assign w_pend      = (r_state == CHECK) && (r_n > CW'(1));

  assign page_ready = (r_state == COLLECT) && (r_n < FULLN);
  assign lk_req     = w_pend;
  assign lk_x       = w_pend ? r_pg[IW'(r_j)] : 7'd0;
  assign lk_y       = w_pend ? r_pg[IW'(r_i)] : 7'd0;
  assign res_valid  = (r_state == REPORT);
  assign res_ok     = (r_state == REPORT) && r_ok;
  assign res_err    = (r_state == REPORT) && r_err;
  assign res_mid    = (r_state == REPORT) ? w_mid : 7'd0;
  assign sum_out    = r_sum;
  assign ok_count   = r_cnt;

  // Page store needs no reset: contents are only read after being written.
  always_ff @(posedge clk) begin
    if (w_acc) r_pg[IW'(r_n)] <= page_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= COLLECT;
      r_n     <= '0;
      r_i     <= '0;
      r_j     <= '0;
      r_err   <= 1'b0;
      r_ok    <= 1'b0;
      r_sum   <= '0;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        COLLECT: begin
          if (w_acc) begin
            r_n <= r_n + 1'b1;
            if (page_last || w_full) begin
              r_err   <= !page_last;
              r_ok    <= 1'b1;
              r_i     <= '0;
              r_j     <= CW'(1);
              r_state <= CHECK;
            end
          end
        end
        CHECK: begin
          if (r_n <= CW'(1)) r_state <= REPORT;
          else if (lk_gnt) r_state <= WAIT_HIT;
        end
        WAIT_HIT: begin
          if (lk_hit) begin
            r_ok    <= 1'b0;
            r_state <= REPORT;
          end else if (w_last_pair) begin
            r_state <= REPORT;
          end else begin
            r_state <= CHECK;
            if (w_row_end) begin
              r_i <= r_i + 1'b1;
              r_j <= r_i + CW'(2);
            end else begin
              r_j <= r_j + 1'b1;
            end
          end
        end
        REPORT: begin
          if (r_ok) begin
            r_sum <= r_sum + SUM_W'(w_mid);
            r_cnt <= r_cnt + 16'd1;
          end
          r_n     <= '0;
          r_err   <= 1'b0;
          r_state <= COLLECT;
        end
        default: r_state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_page_order_sched.sv
// Bench for page_order_sched: table vectors, random updates vs a pair-scan
// reference, reset mid-lookup, and truncation on a MAX_PAGES=4 instance.
module tb_page_order_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [6:0]  page_in;
  logic        page_valid, page_last, page_ready;
  logic        lk_req, lk_gnt = 1'b0, lk_hit = 1'b0;
  logic [6:0]  lk_x, lk_y, res_mid;
  logic        res_valid, res_ok, res_err;
  logic [31:0] sum_out;
  logic [15:0] ok_count;

  logic [6:0]  page_in_b;
  logic        page_valid_b, page_last_b, page_ready_b;
  logic        lk_req_b, lk_gnt_b, lk_hit_b;
  logic [6:0]  lk_x_b, lk_y_b, res_mid_b;
  logic        res_valid_b, res_ok_b, res_err_b;
  logic [31:0] sum_out_b;
  logic [15:0] ok_count_b;

  page_order_sched dut (
    .clk(clk), .rst_n(rst_n),
    .page_in(page_in), .page_valid(page_valid),
    .page_last(page_last), .page_ready(page_ready),
    .lk_req(lk_req), .lk_x(lk_x), .lk_y(lk_y),
    .lk_gnt(lk_gnt), .lk_hit(lk_hit),
    .res_valid(res_valid), .res_ok(res_ok),
    .res_mid(res_mid), .res_err(res_err),
    .sum_out(sum_out), .ok_count(ok_count)
  );

  page_order_sched #(.MAX_PAGES(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .page_in(page_in_b), .page_valid(page_valid_b),
    .page_last(page_last_b), .page_ready(page_ready_b),
    .lk_req(lk_req_b), .lk_x(lk_x_b), .lk_y(lk_y_b),
    .lk_gnt(lk_gnt_b), .lk_hit(lk_hit_b),
    .res_valid(res_valid_b), .res_ok(res_ok_b),
    .res_mid(res_mid_b), .res_err(res_err_b),
    .sum_out(sum_out_b), .ok_count(ok_count_b)
  );

  typedef logic [6:0] pg_t [8];
  typedef struct {
    pg_t        pg;
    int         n;
    int         gw;
    bit         ok;
    logic [6:0] mid;
    int         nq;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  bit          rules [128][128];
  int          gnt_wait = 0;
  int          qcnt = 0;
  logic [13:0] exp_q [$];
  logic [31:0] m_sum = 0;
  logic [15:0] m_cnt = 0;
  logic [8:0]  b_res [$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Lookup responder for the main instance: programmable grant delay,
  // hit answer one cycle after grant, junk on lk_hit/lk_gnt otherwise.
  logic       hit_pend = 1'b0, hold = 1'b0;
  logic [6:0] hx, hy, sx, sy;
  int         wcnt = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      hit_pend = 1'b0;
      hold     = 1'b0;
      wcnt     = 0;
      lk_gnt   = 1'b0;
      lk_hit   = 1'b0;
    end else begin
      lk_hit   = hit_pend ? rules[hx][hy] : 1'($urandom_range(0, 1));
      hit_pend = 1'b0;
      if (hold) begin
        chk("hold_req", 32'(lk_req), 32'd1);
        chk("hold_xy", 32'({lk_x, lk_y}), 32'({sx, sy}));
      end
      hold = 1'b0;
      if (lk_req) begin
        if (wcnt < gnt_wait) begin
          lk_gnt = 1'b0;
          wcnt++;
          hold = 1'b1;
          sx = lk_x;
          sy = lk_y;
        end else begin
          lk_gnt   = 1'b1;
          wcnt     = 0;
          hit_pend = 1'b1;
          hx = lk_x;
          hy = lk_y;
          qcnt++;
          if (exp_q.size() == 0) fail_now("spurious_query");
          else chk("query_xy", 32'({lk_x, lk_y}), 32'(exp_q.pop_front()));
        end
      end else begin
        lk_gnt = 1'($urandom_range(0, 1));
        wcnt   = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (res_valid_b) b_res.push_back({res_ok_b, res_err_b, res_mid_b});
  end

  // Reference: every pair i<j in scan order is queried as (page[j], page[i]);
  // the first existing rule ends the scan with a not-ok verdict.
  task automatic model(input pg_t pg, input int n, output bit ok,
                       output logic [6:0] mid, output int nq);
    ok = 1'b1;
    nq = 0;
    for (int i = 0; i < n - 1 && ok; i++)
      for (int j = i + 1; j < n && ok; j++) begin
        exp_q.push_back({pg[j], pg[i]});
        nq++;
        if (rules[pg[j]][pg[i]]) ok = 1'b0;
      end
    mid = pg[(n - 1) / 2];
  endtask

  task automatic push_a(input logic [6:0] p, input logic last);
    int t = 0;
    page_in = p;
    page_valid = 1'b1;
    page_last = last;
    while (!page_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (!page_ready) fail_now("push_a_timeout");
    @(posedge clk);
    @(negedge clk);
    page_valid = 1'b0;
    page_last = 1'b0;
  endtask

  task automatic push_b(input logic [6:0] p, input logic last);
    int t = 0;
    page_in_b = p;
    page_valid_b = 1'b1;
    page_last_b = last;
    while (!page_ready_b && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (!page_ready_b) fail_now("push_b_timeout");
    @(posedge clk);
    @(negedge clk);
    page_valid_b = 1'b0;
    page_last_b = 1'b0;
  endtask

  task automatic run_update(input pg_t pg, input int n, input bit e_ok,
                            input logic [6:0] e_mid, input int e_nq,
                            input string tag);
    int q0 = qcnt;
    int t = 0;
    for (int k = 0; k < n; k++) push_a(pg[k], k == n - 1);
    while (!res_valid && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (!res_valid) begin
      fail_now({tag, "_timeout"});
      return;
    end
    chk({tag, "_ok"}, 32'(res_ok), 32'(e_ok));
    chk({tag, "_mid"}, 32'(res_mid), 32'(e_mid));
    chk({tag, "_err"}, 32'(res_err), 32'd0);
    chk({tag, "_nq"}, 32'(qcnt - q0), 32'(e_nq));
    chk({tag, "_qleft"}, 32'(exp_q.size()), 32'd0);
    if (e_ok) begin
      m_sum = m_sum + 32'(e_mid);
      m_cnt = m_cnt + 16'd1;
    end
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(res_valid), 32'd0);
    chk({tag, "_sum"}, sum_out, m_sum);
    chk({tag, "_cnt"}, 32'(ok_count), 32'(m_cnt));
  endtask

  task automatic spec_rules();
    foreach (rules[a, b]) rules[a][b] = 1'b0;
    rules[47][53] = 1'b1;
    rules[97][13] = 1'b1;
    rules[97][75] = 1'b1;
    rules[75][47] = 1'b1;
    rules[75][53] = 1'b1;
    rules[61][53] = 1'b1;
    rules[29][13] = 1'b1;
  endtask

  vec_t       tbl [8];
  bit         m_ok;
  logic [6:0] m_mid;
  int         m_nq;
  pg_t        rpg;
  int         rn;
  int         t;

  initial begin
    tbl[0] = '{'{7'd75, 7'd47, 7'd61, 7'd53, 7'd29, 7'd0, 7'd0, 7'd0}, 5, 0, 1'b1, 7'd61, 10};
    tbl[1] = '{'{7'd75, 7'd97, 7'd47, 7'd61, 7'd53, 7'd0, 7'd0, 7'd0}, 5, 0, 1'b0, 7'd47, 1};
    tbl[2] = '{'{7'd75, 7'd47, 7'd61, 7'd53, 7'd29, 7'd0, 7'd0, 7'd0}, 5, 5, 1'b1, 7'd61, 10};
    tbl[3] = '{'{7'd75, 7'd97, 7'd47, 7'd61, 7'd53, 7'd0, 7'd0, 7'd0}, 5, 5, 1'b0, 7'd47, 1};
    tbl[4] = '{'{7'd42, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0}, 1, 0, 1'b1, 7'd42, 0};
    tbl[5] = '{'{7'd47, 7'd53, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0}, 2, 1, 1'b1, 7'd47, 1};
    tbl[6] = '{'{7'd53, 7'd47, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0}, 2, 0, 1'b0, 7'd53, 1};
    tbl[7] = '{'{7'd97, 7'd75, 7'd47, 7'd53, 7'd13, 7'd29, 7'd0, 7'd0}, 6, 2, 1'b0, 7'd47, 15};

    rst_n = 1'b0;
    page_in = '0; page_valid = 1'b0; page_last = 1'b0;
    page_in_b = '0; page_valid_b = 1'b0; page_last_b = 1'b0;
    lk_gnt_b = 1'b1; lk_hit_b = 1'b0;
    spec_rules();
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(page_ready), 32'd1);
    chk("rst_req", 32'(lk_req), 32'd0);
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_sum", sum_out, 32'd0);
    chk("rst_cnt", 32'(ok_count), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (tbl[k]) begin
      gnt_wait = tbl[k].gw;
      model(tbl[k].pg, tbl[k].n, m_ok, m_mid, m_nq);
      run_update(tbl[k].pg, tbl[k].n, tbl[k].ok, tbl[k].mid, tbl[k].nq,
                 $sformatf("tbl%0d", k));
    end

    // Reset while the first grant's answer is pending.
    gnt_wait = 0;
    model(tbl[0].pg, tbl[0].n, m_ok, m_mid, m_nq);
    for (int k = 0; k < 5; k++) push_a(tbl[0].pg[k], k == 4);
    t = 0;
    do begin
      @(negedge clk);
      #1;
      t++;
    end while (!(lk_req && lk_gnt) && t < 200);
    if (!(lk_req && lk_gnt)) fail_now("rstmid_no_grant");
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rstmid_ready", 32'(page_ready), 32'd1);
    chk("rstmid_req", 32'(lk_req), 32'd0);
    chk("rstmid_xy", 32'({lk_x, lk_y}), 32'd0);
    chk("rstmid_res", 32'({res_valid, res_ok, res_err, res_mid}), 32'd0);
    chk("rstmid_sum", sum_out, 32'd0);
    chk("rstmid_cnt", 32'(ok_count), 32'd0);
    @(negedge clk);
    exp_q.delete();
    m_sum = 0;
    m_cnt = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    model(tbl[0].pg, tbl[0].n, m_ok, m_mid, m_nq);
    run_update(tbl[0].pg, tbl[0].n, 1'b1, 7'd61, 10, "after_rst");

    // Random rules over a small page pool so violations are common but not certain.
    foreach (rules[a, b]) rules[a][b] = 1'b0;
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        if (a != b && $urandom_range(0, 11) == 0) rules[a][b] = 1'b1;
    for (int u = 0; u < 30; u++) begin
      rn = $urandom_range(1, 8);
      foreach (rpg[k]) rpg[k] = 7'($urandom_range(0, 15));
      gnt_wait = $urandom_range(0, 2);
      model(rpg, rn, m_ok, m_mid, m_nq);
      run_update(rpg, rn, m_ok, m_mid, m_nq, $sformatf("rnd%0d", u));
    end

    // Truncation on the 4-page instance; the 5th page starts the next update.
    for (int k = 0; k < 4; k++) push_b(7'(11 + k), 1'b0);
    chk("b_ready_full", 32'(page_ready_b), 32'd0);
    push_b(7'd15, 1'b0);
    push_b(7'd16, 1'b0);
    push_b(7'd17, 1'b1);
    t = 0;
    while (b_res.size() < 2 && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("b_nres", 32'(b_res.size()), 32'd2);
    if (b_res.size() >= 2) begin
      chk("b_res0", 32'(b_res[0]), 32'({1'b1, 1'b1, 7'd12}));
      chk("b_res1", 32'(b_res[1]), 32'({1'b1, 1'b0, 7'd16}));
    end
    @(negedge clk);
    chk("b_sum", sum_out_b, 32'd28);
    chk("b_cnt", 32'(ok_count_b), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/page_order_sched.md
PAGE_ORDER_SCHED -- requirements
Module: page_order_sched

Interface
REQ-001 Parameter MAX_PAGES, default 32: maximum pages buffered per update (power of two, 2..64).
REQ-002 Parameter SUM_W, default 32: width of the running sum of middle pages.
REQ-003 clk  in  1  clock; all logic is rising-edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 page_in  in  7  page number of the current update (0..127).
REQ-006 page_valid  in  1  page_in is valid.
REQ-007 page_last  in  1  qualifies page_in as the final page of the update.
REQ-008 page_ready  out  1  block accepts a page this cycle.
REQ-009 lk_req  out  1  request to the shared rule-lookup port.
REQ-010 lk_x, lk_y  out  7 each  query "does rule lk_x|lk_y exist".
REQ-011 lk_gnt  in  1  lookup port grants the request this cycle.
REQ-012 lk_hit  in  1  lookup answer; valid exactly one cycle after the grant cycle.
REQ-013 res_valid  out  1  one-cycle pulse: an update verdict is presented.
REQ-014 res_ok  out  1  the update is correctly ordered; qualified by res_valid.
REQ-015 res_mid  out  7  middle page of the update; qualified by res_valid.
REQ-016 res_err  out  1  the update was truncated at MAX_PAGES; qualified by res_valid.
REQ-017 sum_out  out  SUM_W  running sum of res_mid over all ok updates.
REQ-018 ok_count  out  16  number of ok updates since reset.

Function
REQ-019 FSM states: COLLECT, CHECK, WAIT_HIT, REPORT; reset state COLLECT.
REQ-020 COLLECT: page_ready = 1 only while fewer than MAX_PAGES pages are buffered; a page is accepted on page_valid && page_ready and stored at index N, then N increments.
REQ-021 Accepted page with page_last -> CHECK next cycle; page_ready = 0 outside COLLECT.
REQ-022 Accepting page number MAX_PAGES without page_last -> treated as last; err flag set; CHECK next cycle.
REQ-023 CHECK iterates pairs (i,j), i<j, i outer ascending from 0, j inner ascending from i+1; per pair it drives lk_req=1, lk_x=page[j], lk_y=page[i], all held stable until lk_gnt=1 is sampled.
REQ-024 Grant -> WAIT_HIT for one cycle; lk_req=0 in WAIT_HIT; lk_hit sampled there.
REQ-025 lk_hit=1 -> violation: pair scan stops, the result is not ok, REPORT next cycle.
REQ-026 lk_hit=0 -> next pair in CHECK; after the last pair (i=N-2, j=N-1) -> REPORT with the result ok.
REQ-027 N=1: no lookups issued; CHECK -> REPORT directly; result ok.
REQ-028 Query count for a fully ok update = N*(N-1)/2; exactly one lk_req/lk_gnt handshake per pair; no request is issued without a pending pair.
REQ-029 Middle page = page[(N-1)>>1]; for even N this is the lower middle.
REQ-030 REPORT lasts one cycle: res_valid=1, res_ok, res_mid, res_err driven. If ok: sum_out += res_mid (mod 2^SUM_W) and ok_count += 1 (wraps), both visible the cycle after REPORT.
REQ-031 A truncated update (res_err=1) is still checked and reported normally; res_ok reflects only the lookups.
REQ-032 REPORT -> COLLECT; N and err cleared; page_ready may be 1 in the cycle after REPORT.
REQ-033 page_valid while page_ready=0 is ignored; no input buffering beyond the page store.
REQ-034 lk_gnt while lk_req=0 is ignored; lk_hit outside WAIT_HIT is ignored.

Reset
REQ-035 rst_n low at any time, including mid-CHECK with a request outstanding, immediately forces: state COLLECT, N=0, err=0, page_ready=1, lk_req=0, res_valid=0, res_ok=0, res_mid=0, res_err=0, sum_out=0, ok_count=0. lk_x and lk_y are 0. The page store contents are don't-care.

Verification
REQ-036 Rule memory holds 47|53, 97|13, 97|75, 75|47, 75|53, 61|53, 29|13; update 75,47,61,53,29 with lk_gnt tied 1 -> 10 lookups, res_ok=1, res_mid=61, sum_out=61.
REQ-037 Same rules; update 75,97,47,61,53 -> first lookup (x=97, y=75) hits -> exactly 1 lookup, res_ok=0, res_mid=47, sum_out unchanged.
REQ-038 lk_gnt held 0 for 5 cycles on each request -> lk_req, lk_x and lk_y stay stable throughout; verdict identical to the zero-wait case.
REQ-039 Single-page update 42 with page_last -> 0 lookups, res_ok=1, res_mid=42, ok_count increments.
REQ-040 MAX_PAGES=4; six pages sent without page_last -> page_ready=0 after the 4th page; res_err=1; the 5th page is accepted into the next update.
REQ-041 rst_n asserted in WAIT_HIT -> all outputs take their reset values in the same cycle; the next update is processed correctly with sum_out starting from 0.
